// File: rtl/watch_alarm_ctrl_pkg.sv
// Shared constants, FSM state type and load range check for the watch/alarm block.
package watch_alarm_ctrl_pkg;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;

  typedef enum logic [1:0] {
    StStop = 2'd0,
    StRun  = 2'd1,
    StLoad = 2'd2
  } state_e;

  // True when h:m:s is a legal time of day for the given hour modulus.
  function automatic logic in_range(input int unsigned h, input int unsigned m,
                                    input int unsigned s, input int unsigned hour_max);
    return (s <= SEC_MAX) && (m <= MIN_MAX) && (h < hour_max);
  endfunction

endpackage

// File: rtl/watch_alarm_ctrl_sec_prescaler.sv
// Divides clk down to a one-second advance request. tick is a combinational decode of the
// count register and is only meaningful while en is high.
module watch_alarm_ctrl_sec_prescaler #(
  parameter int unsigned CNT_BIT = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic [CNT_BIT-1:0] th,
  output logic               tick
);

  logic [CNT_BIT-1:0] cnt_q, cnt_d;
  logic [CNT_BIT-1:0] th_m1;

  // Terminal-count decode and next count; clr wins over counting, count holds when idle.
  always_comb begin
    th_m1 = (th == '0) ? '0 : th - 1'b1;
    // ">=" so a threshold lowered below the current count fires on the next cycle.
    tick  = en && (cnt_q >= th_m1);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/watch_alarm_ctrl.sv
// Hour:min:sec timekeeper with run/stop control, validated time load and alarm ring/ack.
module watch_alarm_ctrl
  import watch_alarm_ctrl_pkg::*;
#(
  parameter int unsigned CNT_BIT       = 32,
  parameter int unsigned SEC_BIT       = 6,
  parameter int unsigned MIN_BIT       = 6,
  parameter int unsigned HOUR_BIT      = 5,
  parameter int unsigned HOUR_MAX      = 24,
  parameter int unsigned ALARM_LEN_SEC = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_run_en,
  input  logic [CNT_BIT-1:0]  i_cnt_th,
  input  logic                i_set_valid,
  output logic                o_set_ready,
  input  logic [HOUR_BIT-1:0] i_set_hour,
  input  logic [MIN_BIT-1:0]  i_set_min,
  input  logic [SEC_BIT-1:0]  i_set_sec,
  output logic                o_set_err,
  input  logic                i_alarm_en,
  input  logic [HOUR_BIT-1:0] i_alarm_hour,
  input  logic [MIN_BIT-1:0]  i_alarm_min,
  input  logic                i_alarm_ack,
  output logic [HOUR_BIT-1:0] o_hour,
  output logic [MIN_BIT-1:0]  o_min,
  output logic [SEC_BIT-1:0]  o_sec,
  output logic                o_sec_tick,
  output logic                o_day_wrap,
  output logic                o_alarm_ring
);

  localparam logic [SEC_BIT-1:0]  SecLast  = SEC_BIT'(SEC_MAX);
  localparam logic [MIN_BIT-1:0]  MinLast  = MIN_BIT'(MIN_MAX);
  localparam logic [HOUR_BIT-1:0] HourLast = HOUR_BIT'(HOUR_MAX - 1);
  localparam logic [7:0]          AlarmLen = 8'(ALARM_LEN_SEC);

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [HOUR_BIT-1:0] hour_q, hour_d;
  logic [MIN_BIT-1:0]  min_q, min_d;
  logic [SEC_BIT-1:0]  sec_q, sec_d;
  logic                sec_tick_q, sec_tick_d;
  logic                day_wrap_q, day_wrap_d;
  logic                ring_q, ring_d;
  logic [7:0]          ring_cnt_q, ring_cnt_d;

  logic                presc_tick;
  logic                load_acc, load_ok, adv, match;
  logic                sec_wrap, min_wrap, hour_wrap;
  logic [HOUR_BIT-1:0] adv_hour;
  logic [MIN_BIT-1:0]  adv_min;
  logic [SEC_BIT-1:0]  adv_sec;

  watch_alarm_ctrl_sec_prescaler #(
    .CNT_BIT (CNT_BIT)
  ) u_sec_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == StRun),
    .clr   (load_acc && load_ok),
    .th    (i_cnt_th),
    .tick  (presc_tick)
  );

  // Next-state for FSM, time counters and alarm ring.
  always_comb begin
    load_acc = i_set_valid && ready_q;
    load_ok  = in_range(32'(i_set_hour), 32'(i_set_min), 32'(i_set_sec), HOUR_MAX);
    // A load in the same cycle swallows the pending second.
    adv      = presc_tick && !load_acc;

    sec_wrap  = (sec_q == SecLast);
    min_wrap  = sec_wrap && (min_q == MinLast);
    hour_wrap = min_wrap && (hour_q == HourLast);
    adv_sec   = sec_wrap ? '0 : sec_q + 1'b1;
    adv_min   = sec_wrap ? (min_wrap ? '0 : min_q + 1'b1) : min_q;
    adv_hour  = min_wrap ? (hour_wrap ? '0 : hour_q + 1'b1) : hour_q;

    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = 1'b0;
    day_wrap_d = 1'b0;
    err_d      = 1'b0;
    if (load_acc) begin
      if (load_ok) begin
        hour_d = i_set_hour;
        min_d  = i_set_min;
        sec_d  = i_set_sec;
      end else begin
        err_d = 1'b1;
      end
    end else if (adv) begin
      hour_d     = adv_hour;
      min_d      = adv_min;
      sec_d      = adv_sec;
      sec_tick_d = 1'b1;
      day_wrap_d = hour_wrap;
    end

    // Out-of-range alarm settings can never equal a legal time, so they simply never match.
    match = adv && i_alarm_en && (adv_hour == i_alarm_hour) && (adv_min == i_alarm_min) &&
            (adv_sec == '0);

    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
    if (match) begin
      ring_d     = 1'b1;
      ring_cnt_d = AlarmLen;
    end else if (i_alarm_ack || !i_alarm_en) begin
      ring_d     = 1'b0;
      ring_cnt_d = '0;
    end else if (adv && ring_q) begin
      ring_cnt_d = ring_cnt_q - 8'd1;
      if (ring_cnt_q <= 8'd1) begin
        ring_d = 1'b0;
      end
    end

    state_d = state_q;
    unique case (state_q)
      StStop: begin
        if (load_acc)      state_d = StLoad;
        else if (i_run_en) state_d = StRun;
      end
      StRun: begin
        if (load_acc)       state_d = StLoad;
        else if (!i_run_en) state_d = StStop;
      end
      StLoad:  state_d = i_run_en ? StRun : StStop;
      default: state_d = StStop;
    endcase
    ready_d = (state_d != StLoad);
  end

  // All state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StStop;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
      ring_q     <= 1'b0;
      ring_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      sec_tick_q <= sec_tick_d;
      day_wrap_q <= day_wrap_d;
      ring_q     <= ring_d;
      ring_cnt_q <= ring_cnt_d;
    end
  end

  assign o_set_ready  = ready_q;
  assign o_set_err    = err_q;
  assign o_hour       = hour_q;
  assign o_min        = min_q;
  assign o_sec        = sec_q;
  assign o_sec_tick   = sec_tick_q;
  assign o_day_wrap   = day_wrap_q;
  assign o_alarm_ring = ring_q;

endmodule

// File: tb/tb_watch_alarm_ctrl.sv
// Directed bench for watch_alarm_ctrl: expected snapshots queued at stimulus time, popped and
// compared against the outputs after the stated number of clocks.
module tb_watch_alarm_ctrl;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       tick;
    logic       wrap;
    logic       ring;
    logic       ready;
    logic       err;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  v;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_run_en;
  logic [31:0] i_cnt_th;
  logic        i_set_valid;
  logic        o_set_ready;
  logic [4:0]  i_set_hour;
  logic [5:0]  i_set_min;
  logic [5:0]  i_set_sec;
  logic        o_set_err;
  logic        i_alarm_en;
  logic [4:0]  i_alarm_hour;
  logic [5:0]  i_alarm_min;
  logic        i_alarm_ack;
  logic [4:0]  o_hour;
  logic [5:0]  o_min;
  logic [5:0]  o_sec;
  logic        o_sec_tick;
  logic        o_day_wrap;
  logic        o_alarm_ring;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  watch_alarm_ctrl #(
    .CNT_BIT       (32),
    .SEC_BIT       (6),
    .MIN_BIT       (6),
    .HOUR_BIT      (5),
    .HOUR_MAX      (24),
    .ALARM_LEN_SEC (10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_run_en     (i_run_en),
    .i_cnt_th     (i_cnt_th),
    .i_set_valid  (i_set_valid),
    .o_set_ready  (o_set_ready),
    .i_set_hour   (i_set_hour),
    .i_set_min    (i_set_min),
    .i_set_sec    (i_set_sec),
    .o_set_err    (o_set_err),
    .i_alarm_en   (i_alarm_en),
    .i_alarm_hour (i_alarm_hour),
    .i_alarm_min  (i_alarm_min),
    .i_alarm_ack  (i_alarm_ack),
    .o_hour       (o_hour),
    .o_min        (o_min),
    .o_sec        (o_sec),
    .o_sec_tick   (o_sec_tick),
    .o_day_wrap   (o_day_wrap),
    .o_alarm_ring (o_alarm_ring)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input int h, input int m, input int s, input logic tick,
                              input logic wrap, input logic ring, input logic ready,
                              input logic err);
    obs_t o;
    o.h = 5'(h); o.m = 6'(m); o.s = 6'(s);
    o.tick = tick; o.wrap = wrap; o.ring = ring; o.ready = ready; o.err = err;
    return o;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input obs_t v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    obs_t o;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=0 entries required>=1");
    end else begin
      e = sb.pop_front();
      o = mk(int'(o_hour), int'(o_min), int'(o_sec), o_sec_tick, o_day_wrap, o_alarm_ring,
             o_set_ready, o_set_err);
      assert (o === e.v) else begin
        failures++;
        $error("FAIL %s observed %0d:%0d:%0d tick=%b wrap=%b ring=%b ready=%b err=%b required %0d:%0d:%0d tick=%b wrap=%b ring=%b ready=%b err=%b",
               e.tag, o.h, o.m, o.s, o.tick, o.wrap, o.ring, o.ready, o.err,
               e.v.h, e.v.m, e.v.s, e.v.tick, e.v.wrap, e.v.ring, e.v.ready, e.v.err);
      end
    end
  endtask

  // Queue the expectation, advance n clocks, then compare.
  task automatic expect_after(input string tag, input int n, input obs_t v);
    push(tag, v);
    if (n > 0) step(n);
    check_pop();
  endtask

  task automatic drive_load(input int h, input int m, input int s);
    i_set_valid = 1'b1;
    i_set_hour  = 5'(h);
    i_set_min   = 6'(m);
    i_set_sec   = 6'(s);
  endtask

  initial begin
    reset        = 1'b1;
    i_run_en     = 1'b0;
    i_cnt_th     = 32'd10;
    i_set_valid  = 1'b0;
    i_set_hour   = '0;
    i_set_min    = '0;
    i_set_sec    = '0;
    i_alarm_en   = 1'b0;
    i_alarm_hour = '0;
    i_alarm_min  = '0;
    i_alarm_ack  = 1'b0;
    step(2);
    expect_after("reset_state", 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    expect_after("ready_after_reset", 1, mk(0, 0, 0, 0, 0, 0, 1, 0));

    // Free run at th=10: one edge to enter RUN, then 10 clocks per second.
    i_run_en = 1'b1;
    expect_after("run_before_first_sec", 10, mk(0, 0, 0, 0, 0, 0, 1, 0));
    expect_after("first_sec", 1, mk(0, 0, 1, 1, 0, 0, 1, 0));
    expect_after("tick_one_wide", 1, mk(0, 0, 1, 0, 0, 0, 1, 0));
    expect_after("fifth_sec", 39, mk(0, 0, 5, 1, 0, 0, 1, 0));

    // Stop with prescaler at 6; the stopping edge still counts to 7, so 4 clocks remain.
    step(6);
    i_run_en = 1'b0;
    expect_after("stopped_holds", 20, mk(0, 0, 5, 0, 0, 0, 1, 0));
    i_run_en = 1'b1;
    expect_after("resume_3clk", 3, mk(0, 0, 5, 0, 0, 0, 1, 0));
    expect_after("resume_4clk", 1, mk(0, 0, 6, 1, 0, 0, 1, 0));

    // Legal load and day wrap at th=4.
    i_cnt_th = 32'd4;
    drive_load(23, 59, 58);
    expect_after("load_legal", 1, mk(23, 59, 58, 0, 0, 0, 0, 0));
    i_set_valid = 1'b0;
    expect_after("load_ready_back", 1, mk(23, 59, 58, 0, 0, 0, 1, 0));
    expect_after("pre_59", 3, mk(23, 59, 58, 0, 0, 0, 1, 0));
    expect_after("sec_59", 1, mk(23, 59, 59, 1, 0, 0, 1, 0));
    expect_after("day_wrap", 4, mk(0, 0, 0, 1, 1, 0, 1, 0));
    expect_after("day_wrap_one_wide", 1, mk(0, 0, 0, 0, 0, 0, 1, 0));

    // Illegal load: error pulse, time kept, ready low for one cycle.
    drive_load(12, 60, 0);
    expect_after("load_illegal_err", 1, mk(0, 0, 0, 0, 0, 0, 0, 1));
    i_set_valid = 1'b0;
    expect_after("load_illegal_after", 1, mk(0, 0, 0, 0, 0, 0, 1, 0));
    i_run_en = 1'b0;
    step(1);

    // Alarm without ack: ring at 07:30:00, self-clears at 07:30:10.
    i_cnt_th     = 32'd2;
    i_alarm_en   = 1'b1;
    i_alarm_hour = 5'd7;
    i_alarm_min  = 6'd30;
    drive_load(7, 29, 59);
    expect_after("alarm_load", 1, mk(7, 29, 59, 0, 0, 0, 0, 0));
    i_set_valid = 1'b0;
    i_run_en    = 1'b1;
    step(1);
    expect_after("alarm_ring", 2, mk(7, 30, 0, 1, 0, 1, 1, 0));
    expect_after("alarm_ring_09", 18, mk(7, 30, 9, 1, 0, 1, 1, 0));
    expect_after("alarm_timeout", 2, mk(7, 30, 10, 1, 0, 0, 1, 0));

    // Alarm with ack at 07:30:03.
    drive_load(7, 29, 59);
    step(1);
    i_set_valid = 1'b0;
    step(1);
    expect_after("alarm2_ring", 2, mk(7, 30, 0, 1, 0, 1, 1, 0));
    expect_after("alarm2_at_03", 6, mk(7, 30, 3, 1, 0, 1, 1, 0));
    i_alarm_ack = 1'b1;
    expect_after("alarm_ack", 1, mk(7, 30, 3, 0, 0, 0, 1, 0));
    i_alarm_ack = 1'b0;

    // Load on the advancing cycle (prescaler at 9 of th=10): load wins, no tick, no alarm.
    i_cnt_th     = 32'd10;
    i_alarm_hour = 5'd1;
    i_alarm_min  = 6'd2;
    step(8);
    drive_load(1, 2, 3);
    expect_after("load_beats_tick", 1, mk(1, 2, 3, 0, 0, 0, 0, 0));
    i_set_valid = 1'b0;
    step(1);

    // Ring again, then async reset mid-cycle.
    i_cnt_th    = 32'd2;
    i_alarm_min = 6'd3;
    drive_load(1, 2, 59);
    step(1);
    i_set_valid = 1'b0;
    step(1);
    expect_after("ring_before_reset", 2, mk(1, 3, 0, 1, 0, 1, 1, 0));
    step(1);
    reset = 1'b1;
    #2;
    expect_after("async_reset", 0, mk(0, 0, 0, 0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
